// File: rtl/beta_pkg.sv
// Shared constants and types for the Beta pipeline hazard controller.
package beta_pkg;

    localparam int BETA_NREG = 32;
    localparam int BETA_AW   = 5;

    localparam logic [BETA_AW-1:0] R31 = BETA_AW'(BETA_NREG - 1);

    localparam logic [1:0] IRSRC_IR  = 2'd0;
    localparam logic [1:0] IRSRC_BNE = 2'd1;
    localparam logic [1:0] IRSRC_NOP = 2'd2;

    localparam logic [1:0] BYP_RF  = 2'd0;
    localparam logic [1:0] BYP_ALU = 2'd1;
    localparam logic [1:0] BYP_MEM = 2'd2;
    localparam logic [1:0] BYP_WB  = 2'd3;

    typedef struct packed {
        logic               valid;
        logic [BETA_AW-1:0] rc;
        logic               is_ld;
    } stage_t;

endpackage

// File: rtl/beta_byp_sel.sv
// Per-operand bypass priority compare (ALU > MEM > WB) with load-use detection.
module beta_byp_sel
    import beta_pkg::*;
#(
    parameter logic [BETA_AW-1:0] P_R31 = R31
) (
    input  logic [BETA_AW-1:0] i_ra,
    input  logic               i_use,
    input  stage_t             i_alu,
    input  stage_t             i_mem,
    input  stage_t             i_wb,
    output logic [1:0]         o_sel,
    output logic               o_load_haz
);

    logic w_live;
    logic w_hit_alu;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_live    = i_use && (i_ra != P_R31);
    assign w_hit_alu = w_live && i_alu.valid && (i_alu.rc == i_ra);
    assign w_hit_mem = w_live && i_mem.valid && (i_mem.rc == i_ra);
    assign w_hit_wb  = w_live && i_wb.valid  && (i_wb.rc  == i_ra);

    // A load still in ALU or MEM has no data yet: the select stays on the
    // regfile and the caller stalls until the load reaches WB.
    always_comb begin
        o_sel      = BYP_RF;
        o_load_haz = 1'b0;
        if (w_hit_alu) begin
            if (i_alu.is_ld) o_load_haz = 1'b1;
            else             o_sel      = BYP_ALU;
        end else if (w_hit_mem) begin
            if (i_mem.is_ld) o_load_haz = 1'b1;
            else             o_sel      = BYP_MEM;
        end else if (w_hit_wb) begin
            o_sel = BYP_WB;
        end
    end

endmodule

// File: rtl/beta_hazard_ctl.sv
// Beta 5-stage hazard controller: scoreboard, bypass selects, load-use stall,
// branch annulment, memory-wait freeze and interrupt injection.
module beta_hazard_ctl
    import beta_pkg::*;
#(
    parameter int NREG = BETA_NREG,
    parameter int AW   = BETA_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rf_ra1,
    input  logic [AW-1:0] rf_ra2,
    input  logic          rf_use_a,
    input  logic          rf_use_b,
    input  logic          rf_wr,
    input  logic [AW-1:0] rf_rc,
    input  logic          rf_is_ld,
    input  logic [1:0]    rf_pcsel,
    input  logic          rf_super,
    input  logic          mem_ready,
    input  logic          irq,
    output logic          stall,
    output logic          freeze,
    output logic [1:0]    irsrc,
    output logic [1:0]    byp_a,
    output logic [1:0]    byp_b,
    output logic          irq_ack
);

    stage_t r_sb_alu;
    stage_t r_sb_mem;
    stage_t r_sb_wb;
    logic   r_annul;
    logic   r_irq_pend;

    stage_t w_rf_entry;
    logic   w_haz_a;
    logic   w_haz_b;
    logic   w_take;

    beta_byp_sel #(.P_R31(BETA_AW'(NREG - 1))) u_sel_a (
        .i_ra       (rf_ra1),
        .i_use      (rf_use_a),
        .i_alu      (r_sb_alu),
        .i_mem      (r_sb_mem),
        .i_wb       (r_sb_wb),
        .o_sel      (byp_a),
        .o_load_haz (w_haz_a)
    );

    beta_byp_sel #(.P_R31(BETA_AW'(NREG - 1))) u_sel_b (
        .i_ra       (rf_ra2),
        .i_use      (rf_use_b),
        .i_alu      (r_sb_alu),
        .i_mem      (r_sb_mem),
        .i_wb       (r_sb_wb),
        .o_sel      (byp_b),
        .o_load_haz (w_haz_b)
    );

    assign freeze  = !mem_ready;
    assign stall   = freeze || w_haz_a || w_haz_b;
    assign w_take  = r_irq_pend && !rf_super && !stall && !r_annul;
    assign irq_ack = w_take;

    always_comb begin
        w_rf_entry       = '0;
        w_rf_entry.valid = rf_wr;
        w_rf_entry.rc    = rf_rc;
        w_rf_entry.is_ld = rf_is_ld;
    end

    always_comb begin
        irsrc = IRSRC_IR;
        if (r_annul)     irsrc = IRSRC_NOP;
        else if (w_take) irsrc = IRSRC_BNE;
    end

    // Annul starts set so the first instruction after reset is squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sb_alu   <= '0;
            r_sb_mem   <= '0;
            r_sb_wb    <= '0;
            r_annul    <= 1'b1;
            r_irq_pend <= 1'b0;
        end else if (!freeze) begin
            r_sb_wb    <= r_sb_mem;
            r_sb_mem   <= r_sb_alu;
            r_sb_alu   <= stall ? '0 : w_rf_entry;
            r_annul    <= (rf_pcsel != 2'd0) && !stall;
            r_irq_pend <= w_take ? 1'b0 : (r_irq_pend || irq);
        end
    end

endmodule

// File: tb/tb_beta_hazard_ctl.sv
// Directed cycle-by-cycle vector bench for beta_hazard_ctl.
module tb_beta_hazard_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rf_ra1, rf_ra2, rf_rc;
    logic       rf_use_a, rf_use_b, rf_wr, rf_is_ld, rf_super, mem_ready, irq;
    logic [1:0] rf_pcsel;
    logic       stall, freeze, irq_ack;
    logic [1:0] irsrc, byp_a, byp_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [4:0] ra1, ra2, rc;
        logic       ua, ub, wr, ld, irq, sup, mr;
        logic [1:0] pc;
        logic       e_stall, e_ack;
        logic [1:0] e_irsrc, e_ba, e_bb;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    beta_hazard_ctl dut (
        .clk       (clk),
        .reset     (reset),
        .rf_ra1    (rf_ra1),
        .rf_ra2    (rf_ra2),
        .rf_use_a  (rf_use_a),
        .rf_use_b  (rf_use_b),
        .rf_wr     (rf_wr),
        .rf_rc     (rf_rc),
        .rf_is_ld  (rf_is_ld),
        .rf_pcsel  (rf_pcsel),
        .rf_super  (rf_super),
        .mem_ready (mem_ready),
        .irq       (irq),
        .stall     (stall),
        .freeze    (freeze),
        .irsrc     (irsrc),
        .byp_a     (byp_a),
        .byp_b     (byp_b),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name,
                                input logic [4:0] ra1, input logic ua,
                                input logic [4:0] ra2, input logic ub,
                                input logic wr, input logic [4:0] rc, input logic ld,
                                input logic [1:0] pc, input logic irq_i, input logic sup,
                                input logic mr,
                                input logic e_stall, input logic [1:0] e_irsrc,
                                input logic [1:0] e_ba, input logic [1:0] e_bb,
                                input logic e_ack);
        vec_t v;
        v.name = name; v.ra1 = ra1; v.ua = ua; v.ra2 = ra2; v.ub = ub;
        v.wr = wr; v.rc = rc; v.ld = ld; v.pc = pc; v.irq = irq_i; v.sup = sup; v.mr = mr;
        v.e_stall = e_stall; v.e_irsrc = e_irsrc; v.e_ba = e_ba; v.e_bb = e_bb; v.e_ack = e_ack;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rf_ra1 = v.ra1; rf_use_a = v.ua; rf_ra2 = v.ra2; rf_use_b = v.ub;
        rf_wr = v.wr; rf_rc = v.rc; rf_is_ld = v.ld; rf_pcsel = v.pc;
        irq = v.irq; rf_super = v.sup; mem_ready = v.mr;
    endtask

    task automatic check(input string name, input logic e_stall, input logic e_freeze,
                         input logic [1:0] e_irsrc, input logic [1:0] e_ba,
                         input logic [1:0] e_bb, input logic e_ack);
        n_vec++;
        if (stall !== e_stall || freeze !== e_freeze || irsrc !== e_irsrc ||
            byp_a !== e_ba || byp_b !== e_bb || irq_ack !== e_ack) begin
            n_err++;
            $display("FAIL %s: got stall=%0d freeze=%0d irsrc=%0d byp_a=%0d byp_b=%0d ack=%0d, want stall=%0d freeze=%0d irsrc=%0d byp_a=%0d byp_b=%0d ack=%0d",
                     name, stall, freeze, irsrc, byp_a, byp_b, irq_ack,
                     e_stall, e_freeze, e_irsrc, e_ba, e_bb, e_ack);
        end
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        @(negedge clk);
        check(v.name, v.e_stall, !v.mr, v.e_irsrc, v.e_ba, v.e_bb, v.e_ack);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 name            ra1 ua ra2 ub wr rc ld pc irq sup mr | st irs ba bb ack
        vecs[0]  = mk("post_reset_nop",   0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2, 0, 0, 0);
        vecs[1]  = mk("add_r3",           1, 1,  2, 1, 1, 3, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[2]  = mk("byp_alu",          3, 1,  4, 1, 1, 4, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
        vecs[3]  = mk("byp_mem_alu",      3, 1,  4, 1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 2, 1, 0);
        vecs[4]  = mk("byp_wb_mem",       3, 1,  4, 1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 3, 2, 0);
        vecs[5]  = mk("unused_a_wr_r31",  3, 0,  4, 1, 1, 31, 0, 0, 0, 0, 1,  0, 0, 0, 3, 0);
        vecs[6]  = mk("r31_no_hazard",   31, 1, 31, 1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[7]  = mk("ld_r5",            0, 0,  0, 0, 1, 5, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[8]  = mk("ld_use_stall1",    5, 1,  0, 0, 1, 6, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
        vecs[9]  = mk("ld_use_stall2",    5, 1,  0, 0, 1, 6, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
        vecs[10] = mk("ld_use_wb",        5, 1,  0, 0, 1, 6, 0, 0, 0, 0, 1,   0, 0, 3, 0, 0);
        vecs[11] = mk("branch_irq",       0, 0,  0, 0, 0, 0, 0, 2, 1, 0, 1,   0, 0, 0, 0, 0);
        vecs[12] = mk("annul_slot",       0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2, 0, 0, 0);
        vecs[13] = mk("trap_after_br",    0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 1);
        vecs[14] = mk("after_trap",       0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[15] = mk("irq_super",        0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0);
        vecs[16] = mk("super_hold",       0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
        vecs[17] = mk("super_drop_trap",  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 1);
        vecs[18] = mk("single_ack",       0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[19] = mk("ld_r7",            0, 0,  0, 0, 1, 7, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        vecs[20] = mk("br_in_stall1",     0, 0,  7, 1, 0, 0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0);
        vecs[21] = mk("br_in_stall2",     0, 0,  7, 1, 0, 0, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0);
        vecs[22] = mk("br_after_stall",   0, 0,  7, 1, 0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 3, 0);
        vecs[23] = mk("br_annul",         0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 2, 0, 0, 0);
        vecs[24] = mk("add_r8_irq_sup",   0, 0,  0, 0, 1, 8, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0);
        vecs[25] = mk("freeze1",          8, 1,  0, 0, 1, 9, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0);
        vecs[26] = mk("freeze2",          8, 1,  0, 0, 1, 9, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0);
        vecs[27] = mk("freeze3",          8, 1,  0, 0, 1, 9, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0);
        vecs[28] = mk("thaw_trap",        8, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 1);
        vecs[29] = mk("thaw_byp_mem",     8, 1,  0, 0, 1, 8, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0);
        vecs[30] = mk("alu_over_wb",      8, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);

        reset = 1'b1;
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        #2;
        check("in_reset", 0, 0, 2, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset arriving in the middle of a load-use stall.
        drive(mk("ld_r10", 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_ld_r10", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(mk("use_r10", 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        #2;
        check("rst_pre_stall", 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check("rst_assert", 0, 0, 2, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_first_cycle", 0, 0, 2, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_second_cycle", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/beta_hazard_ctl.md
Name: beta_hazard_ctl

Overview:
- Pipeline hazard controller for the 5-stage Beta (IF, RF, ALU, MEM, WB); sits beside the register-fetch stage.
- Tracks destination registers of in-flight ALU/MEM/WB instructions in an internal scoreboard.
- Drives the RF stage's stall and irsrc controls and the operand bypass-mux selects.
- Handles load-use stalls, branch annulment, memory-wait freeze and interrupt injection.

Parameters:
- NREG, 32, architectural register count; register index NREG-1 (R31) never creates a hazard.
- AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- rf_ra1  in  AW  RF operand-A source register
- rf_ra2  in  AW  RF operand-B source register
- rf_use_a  in  1  RF instruction reads ra1
- rf_use_b  in  1  RF instruction reads ra2
- rf_wr  in  1  RF instruction writes a register
- rf_rc  in  AW  RF destination register
- rf_is_ld  in  1  RF instruction is LD/LDR; data is ready only in WB
- rf_pcsel  in  2  RF branch decision; nonzero means redirect
- rf_super  in  1  RF PC supervisor bit; masks IRQ
- mem_ready  in  1  data memory done; 0 freezes the whole pipe
- irq  in  1  level interrupt request
- stall  out  1  hold PC, IF and RF registers
- freeze  out  1  hold all pipeline registers (= !mem_ready)
- irsrc  out  2  RF IR source: 0 fetched, 1 BNE trap, 2 NOP
- byp_a  out  2  operand-A select: 0 regfile, 1 ALU, 2 MEM, 3 WB
- byp_b  out  2  operand-B select, same encoding as byp_a
- irq_ack  out  1  one-cycle pulse when a trap is injected

Behaviour:
- Scoreboard: three stage entries (ALU, MEM, WB), each holding {valid, rc, is_ld}.
- Scoreboard advance on posedge clk when freeze=0:
  - WB<=MEM, MEM<=ALU.
  - ALU<=RF info {rf_wr, rf_rc, rf_is_ld}, or a bubble (valid=0) when stall=1.
- When freeze=1, all state holds and stall is forced to 1.
- Match(stage,r): valid AND rc==r AND r!=NREG-1 AND operand used.
- Bypass select, combinational, per operand:
  - Priority is ALU > MEM > WB; default 0.
  - A match on an is_ld entry in ALU or MEM does not bypass; it raises load_hazard instead.
  - An is_ld entry in WB bypasses normally (select 3).
- stall = freeze OR load_hazard. Worst case is 2 bubbles (load immediately followed by a user).
- Annul flop: set on a clock where rf_pcsel!=0 AND stall=0, cleared otherwise.
- irsrc priority, combinational: annul -> 2; else irq_take -> 1; else 0.
  - irq_take = irq_pending AND !rf_super AND !stall AND !annul.
  - A taken branch therefore defers the trap by at least one cycle.
- irq_pending: set when irq=1 is sampled; cleared on the clock where irq_take=1.
- irq_ack = irq_take; exactly one pulse per injection.
- Simultaneous events:
  - freeze with a branch: the annul flop holds.
  - freeze with IRQ: irq_pending holds and no ack is issued.
- Reset (async):
  - All scoreboard valids = 0; annul = 1, so the first post-reset RF instruction is a NOP; irq_pending = 0.
  - Outputs during reset: stall=0, irsrc=2, byp_a=byp_b=0, irq_ack=0. freeze still follows mem_ready.
  - Reset mid-stall drops the stall on reset assertion.

Decomposition:
- Shared package beta_pkg holds:
  - irsrc encodings IRSRC_IR=0, IRSRC_BNE=1, IRSRC_NOP=2.
  - bypass encodings BYP_RF/BYP_ALU/BYP_MEM/BYP_WB.
  - R31 constant.
  - stage-entry struct {valid, rc, is_ld}.
- One sub-module, beta_byp_sel: a combinational per-operand priority compare, instantiated twice (A and B).

Test Plan:
- ADD R3 then SUB reading R3 next cycle, mem_ready=1 -> byp_a=1, stall=0. One cycle later, a reader of R3 -> byp_a=2.
- LD into R5, then ADD R5 immediately -> stall=1 for exactly 2 cycles, ALU receives 2 bubbles, then byp_a=3, stall=0.
- Write to R31 in ALU, reader of R31 -> byp_a=0, no stall.
- rf_pcsel=2 for one cycle -> irsrc=2 on the next cycle only. With irq pending at the same time, irq_ack follows 1 cycle later with irsrc=1.
- mem_ready=0 for 3 cycles mid-stream -> freeze=stall=1, scoreboard unchanged; bypass resumes identically after mem_ready returns to 1.
- irq=1 with rf_super=1 -> no ack. After rf_super drops, a single irq_ack pulse with irsrc=1.
- reset asserted mid load-stall -> stall=0 and irsrc=2 immediately; first post-reset cycle has valids=0.
